// File: rtl/cpen391_group5_input_debouncer_if.sv
// Debouncer bus: raw switch levels in, debounced levels, edge pulses and sticky event flags out.
interface cpen391_group5_input_debouncer_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] raw_in;
   logic             clear_events;
   logic [WIDTH-1:0] debounced_out;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic [WIDTH-1:0] event_pending;
   logic             any_event;

   modport master (
      output raw_in, clear_events,
      input  debounced_out, rise_pulse, fall_pulse, event_pending, any_event
   );

   modport slave (
      input  raw_in, clear_events,
      output debounced_out, rise_pulse, fall_pulse, event_pending, any_event
   );
endinterface

// File: rtl/cpen391_group5_input_debouncer.sv
// Per-channel switch debouncer: 2-flop synchronizer, STABLE/SETTLING FSM with stability counter,
// registered edge pulses, sticky event flags and a registered any-event summary.
module cpen391_group5_input_debouncer #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned STABLE_CYCLES = 500000,
   parameter int unsigned CNT_W         = 19
) (
   input logic clk,
   input logic reset_n,
   cpen391_group5_input_debouncer_if.slave bus
);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] ep_q, ep_d;
   logic             any_q, any_d;
   state_e           state_q [WIDTH];
   state_e           state_d [WIDTH];
   logic [CNT_W-1:0] cnt_q   [WIDTH];
   logic [CNT_W-1:0] cnt_d   [WIDTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         ep_q    <= '0;
         any_q   <= 1'b0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            state_q[i] <= ST_STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1_q <= bus.raw_in;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         ep_q    <= ep_d;
         any_q   <= any_d;
         for (int i = 0; i < int'(WIDTH); i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Counter only advances while the synchronized level disagrees with the output; equality match commits.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            ST_STABLE: begin
               cnt_d[i] = '0;
               if (sync2_q[i] != deb_q[i]) begin
                  if (cnt_q[i] == CNT_LAST) begin
                     deb_d[i] = sync2_q[i];
                  end else begin
                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                     state_d[i] = ST_SETTLING;
                  end
               end
            end
            ST_SETTLING: begin
               if (sync2_q[i] == deb_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = ST_STABLE;
               end else if (cnt_q[i] == CNT_LAST) begin
                  deb_d[i]   = sync2_q[i];
                  cnt_d[i]   = '0;
                  state_d[i] = ST_STABLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
         endcase
      end
      rise_d = deb_d & ~deb_q;
      fall_d = ~deb_d & deb_q;
      // A new event on a channel overrides a coincident clear.
      ep_d   = (bus.clear_events ? '0 : ep_q) | rise_d | fall_d;
      any_d  = |ep_q;
   end

   assign bus.debounced_out = deb_q;
   assign bus.rise_pulse    = rise_q;
   assign bus.fall_pulse    = fall_q;
   assign bus.event_pending = ep_q;
   assign bus.any_event     = any_q;

endmodule

// File: tb/tb_cpen391_group5_input_debouncer.sv
// Randomized and directed bench for the input debouncer, checked each cycle against a history-window model.
module tb_cpen391_group5_input_debouncer;

   localparam int unsigned W     = 8;
   localparam int unsigned SC    = 4;
   localparam int unsigned CNT_W = 4;

   logic clk;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   cpen391_group5_input_debouncer_if #(.WIDTH(W)) bus ();

   cpen391_group5_input_debouncer #(
      .WIDTH(W), .STABLE_CYCLES(SC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference: an output bit flips at edge n when raw samples n-SC-1 .. n-2 all disagree with it.
   logic [W-1:0] hist [$];
   logic [W-1:0] m_deb, m_rise, m_fall, m_ep, nd;
   logic         m_any, all_diff;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist = {};
         for (int k = 0; k < int'(SC) + 2; k++) hist.push_back('0);
         m_deb = '0; m_rise = '0; m_fall = '0; m_ep = '0; m_any = 1'b0;
      end else begin
         hist.push_back(bus.raw_in);
         void'(hist.pop_front());
         nd = m_deb;
         for (int b = 0; b < int'(W); b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < int'(SC); k++)
               if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_deb[b];
         end
         m_rise = nd & ~m_deb;
         m_fall = ~nd & m_deb;
         m_any  = |m_ep;
         m_ep   = (bus.clear_events ? '0 : m_ep) | m_rise | m_fall;
         m_deb  = nd;
      end
   end

   always @(negedge clk) begin
      #2;
      check_eq("model_deb",  bus.debounced_out, m_deb);
      check_eq("model_rise", bus.rise_pulse, m_rise);
      check_eq("model_fall", bus.fall_pulse, m_fall);
      check_eq("model_ep",   bus.event_pending, m_ep);
      check_eq("model_any",  W'(bus.any_event), W'(m_any));
      check_eq("rise_and_fall", bus.rise_pulse & bus.fall_pulse, '0);
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_pulse();
      bus.clear_events = 1'b1;
      step(1);
      bus.clear_events = 1'b0;
      step(2);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_deb"},  bus.debounced_out, '0);
      check_eq({tag, "_rise"}, bus.rise_pulse, '0);
      check_eq({tag, "_fall"}, bus.fall_pulse, '0);
      check_eq({tag, "_ep"},   bus.event_pending, '0);
      check_eq({tag, "_any"},  W'(bus.any_event), '0);
   endtask

   int           left [W];
   logic [W-1:0] r;
   int           hold;

   initial begin
      bus.raw_in       = '0;
      bus.clear_events = 1'b0;
      reset_n          = 1'b1;
      #1 reset_n = 1'b0;
      step(3);
      check_all_zero("in_reset");
      reset_n = 1'b1;
      step(1);
      check_all_zero("first_edge");

      // Single-bit rise, held
      bus.raw_in = 8'h01;
      step(5);
      check_eq("r32_deb_edge5", bus.debounced_out, 8'h00);
      step(1);
      check_eq("r32_deb_edge6", bus.debounced_out, 8'h01);
      check_eq("r32_rise", bus.rise_pulse, 8'h01);
      check_eq("r32_ep", bus.event_pending, 8'h01);
      check_eq("r32_any_lag", W'(bus.any_event), '0);
      step(1);
      check_eq("r32_rise_off", bus.rise_pulse, 8'h00);
      check_eq("r32_any", W'(bus.any_event), W'(1'b1));

      // Three-cycle glitch is rejected
      bus.raw_in = 8'h00;
      step(8);
      clear_pulse();
      bus.raw_in = 8'h01;
      step(3);
      bus.raw_in = 8'h00;
      step(8);
      check_eq("r33_deb", bus.debounced_out, 8'h00);
      check_eq("r33_ep", bus.event_pending, 8'h00);

      // Multi-bit simultaneous rise and fall
      bus.raw_in = 8'hA5;
      step(5);
      check_eq("r34_deb_edge5", bus.debounced_out, 8'h00);
      step(1);
      check_eq("r34_deb", bus.debounced_out, 8'hA5);
      check_eq("r34_rise", bus.rise_pulse, 8'hA5);
      step(2);
      bus.raw_in = 8'h00;
      step(6);
      check_eq("r34_fall", bus.fall_pulse, 8'hA5);
      check_eq("r34_deb_fall", bus.debounced_out, 8'h00);
      step(2);

      // Set beats a coincident clear
      clear_pulse();
      bus.raw_in = 8'h01;
      step(8);
      check_eq("r35_ep_pre", bus.event_pending, 8'h01);
      bus.raw_in = 8'h03;
      step(5);
      bus.clear_events = 1'b1;
      step(1);
      bus.clear_events = 1'b0;
      check_eq("r35_rise", bus.rise_pulse, 8'h02);
      check_eq("r35_ep", bus.event_pending, 8'h02);

      // Reset in the middle of settling
      bus.raw_in = 8'h00;
      step(1);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      step(2);
      bus.raw_in = 8'h08;
      step(4);
      reset_n = 1'b0;
      step(1);
      check_all_zero("r36_reset");
      reset_n = 1'b1;
      step(5);
      check_eq("r36_deb_edge5", bus.debounced_out, 8'h00);
      check_eq("r36_no_rise", bus.rise_pulse, 8'h00);
      step(1);
      check_eq("r36_deb", bus.debounced_out, 8'h08);
      check_eq("r36_rise", bus.rise_pulse, 8'h08);
      step(1);
      check_eq("r36_rise_once", bus.rise_pulse, 8'h00);

      // Bounce of 1-3 cycle pulses on every bit
      bus.raw_in = 8'h00;
      step(8);
      clear_pulse();
      for (int b = 0; b < int'(W); b++) left[b] = 0;
      for (int c = 0; c < 10000; c++) begin
         r = bus.raw_in;
         for (int b = 0; b < int'(W); b++) begin
            if (r[b]) begin
               left[b] = left[b] - 1;
               if (left[b] == 0) r[b] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               r[b]    = 1'b1;
               left[b] = int'($urandom_range(1, 3));
            end
         end
         bus.raw_in = r;
         step(1);
      end
      bus.raw_in = 8'h00;
      step(8);
      check_eq("r37_deb", bus.debounced_out, 8'h00);
      check_eq("r37_ep", bus.event_pending, 8'h00);
      check_eq("r37_any", W'(bus.any_event), '0);

      // Random levels with random hold times and clears
      for (int it = 0; it < 400; it++) begin
         hold             = int'($urandom_range(1, 8));
         bus.raw_in       = W'($urandom);
         bus.clear_events = ($urandom_range(0, 9) == 0);
         step(hold);
      end
      bus.clear_events = 1'b0;
      step(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpen391_group5_input_debouncer.md
CPEN391_GROUP5_INPUT_DEBOUNCER -- requirements
Module: cpen391_group5_input_debouncer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of independent input channels.
REQ-002 Parameter STABLE_CYCLES, default 500000 (10 ms at 50 MHz), SHALL set the consecutive-cycle stability requirement; the legal range is 1 to 2^CNT_W-1.
REQ-003 Parameter CNT_W, default 19, SHALL set the per-channel counter width.
REQ-004 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 raw_in  input  WIDTH  SHALL carry asynchronous switch/button levels.
REQ-007 clear_events  input  1  SHALL be a synchronous strobe that clears event_pending.
REQ-008 debounced_out  output  WIDTH  SHALL be the registered stable levels that drive the PIO in_port.
REQ-009 rise_pulse  output  WIDTH  SHALL give a one-cycle pulse per channel on each debounced 0->1 transition.
REQ-010 fall_pulse  output  WIDTH  SHALL give a one-cycle pulse per channel on each debounced 1->0 transition.
REQ-011 event_pending  output  WIDTH  SHALL hold a sticky per-channel flag for any debounced transition.
REQ-012 any_event  output  1  SHALL be the OR-reduction of event_pending, registered.

Function
REQ-013 Each raw_in bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other logic.
REQ-014 Each channel SHALL implement a 2-state FSM: STABLE (sync2 == debounced_out) and SETTLING (sync2 != debounced_out).
REQ-015 In STABLE, the channel counter SHALL hold 0.
REQ-016 In SETTLING, the counter SHALL increment by 1 per cycle while sync2 differs from debounced_out.
REQ-017 If sync2 returns to equal debounced_out before the count completes, the counter SHALL reset to 0 and the FSM SHALL return to STABLE with no output change (glitch rejected).
REQ-018 When sync2 has differed from debounced_out for STABLE_CYCLES consecutive sampled cycles, debounced_out SHALL take sync2 on the next edge, the counter SHALL reset to 0, and the FSM SHALL return to STABLE.
REQ-019 Latency from the first clk edge that samples a new, held raw_in level into sync1 to the edge that updates debounced_out SHALL be exactly STABLE_CYCLES+2 edges.
REQ-020 The counter SHALL never wrap; it SHALL be compared for equality to STABLE_CYCLES-1 and cleared on that match.
REQ-021 rise_pulse[i] / fall_pulse[i] SHALL be registered, SHALL be high in exactly the cycle debounced_out[i] first shows its new value, and SHALL be low otherwise.
REQ-022 A rise and a fall pulse SHALL never be asserted together on the same channel.
REQ-023 event_pending[i] SHALL be set in the same cycle as either pulse on channel i.
REQ-024 event_pending SHALL be cleared (all bits) on the edge after clear_events=1.
REQ-025 If a set and clear_events coincide on a channel, that channel's set SHALL win.
REQ-026 any_event SHALL lag event_pending by one cycle.
REQ-027 Channels SHALL be fully independent; simultaneous transitions on multiple channels SHALL each meet REQ-019.
REQ-028 With STABLE_CYCLES=1, a change held for one synchronized cycle SHALL update the output (latency 3 edges).

Reset
REQ-029 reset_n low SHALL asynchronously force sync1, sync2, counters, FSMs (STABLE), debounced_out, rise_pulse, fall_pulse, event_pending and any_event to 0.
REQ-030 Reset asserted mid-SETTLING SHALL discard the partial count; after release, a held-high raw_in SHALL produce a rise after the full REQ-019 latency.
REQ-031 No output SHALL pulse during or on the first edge after reset release.

Verification (bench uses STABLE_CYCLES=4, WIDTH=8)
REQ-032 raw_in 0x00->0x01, held: debounced_out=0x01 exactly 6 edges later; rise_pulse=0x01 for 1 cycle; event_pending=0x01; any_event=1 one cycle later.
REQ-033 raw_in[0] 0->1 for 3 synchronized cycles then back to 0: debounced_out stays 0x00; no pulses; event_pending stays 0x00.
REQ-034 raw_in 0x00->0xA5 in a single cycle: all four bits rise together after 6 edges; rise_pulse=0xA5; then 0xA5->0x00 gives fall_pulse=0xA5.
REQ-035 event_pending=0x01 with clear_events=1 in the same cycle as a new rise on bit 1: event_pending=0x02 afterwards.
REQ-036 reset_n pulsed low at count 2 of a bit-3 rise, raw held high: all outputs 0; debounced_out[3]=1 six edges after release; a single rise_pulse.
REQ-037 Random raw_in bounce (1-3-cycle pulses) on all bits for 10000 cycles: no output change; the scoreboard checks REQ-019/REQ-022.
